// File: rtl/idli_pkg.sv
// Shared types for the idli core: slice/counter types and the UART transmitter debug view.
package idli_pkg;

    typedef logic [1:0] ctr_t;
    typedef logic [3:0] slice_t;

    typedef enum logic [1:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_STOP
    } utx_state_t;

    typedef struct packed {
        utx_state_t state;
        logic [2:0] bit_q;
        logic       byte_hi;
        logic       buf_vld;
    } utx_debug_t;

    typedef struct packed {
        logic stall_utx;
    } ex_debug_t;

    typedef struct packed {
        ex_debug_t  ex;
        utx_debug_t utx;
    } debug_t;

endpackage

// File: rtl/idli_utx.sv
// UART transmitter: buffers one 16b word written as four 4b slices, then sends it as two
// back-to-back 8N1 frames (low byte first, LSB first).
module idli_utx
    import idli_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  ctr_t       i_ctr,
    input  logic       i_vld,
    input  slice_t     i_data,
    output logic       o_stall,
    output logic       o_tx,
    output utx_debug_t o_debug
);

    localparam int unsigned      BaudW    = $clog2(CYCLES_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CYCLES_PER_BIT - 1);

    logic [15:0]      buf_q, buf_d;
    logic             buf_vld_q, buf_vld_d;
    logic             cap_q, cap_d;
    logic [15:0]      shift_q, shift_d;
    utx_state_t       state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             byte_hi_q, byte_hi_d;

    logic       wr_first;
    logic       accept;
    logic       baud_done;
    logic       load;
    logic [7:0] cur_byte;

    always_comb begin
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        cap_d     = cap_q;
        shift_d   = shift_q;
        state_d   = state_q;
        baud_d    = baud_q + 1'b1;
        bit_d     = bit_q;
        byte_hi_d = byte_hi_q;
        load      = 1'b0;

        wr_first  = i_vld && (i_ctr == 2'd0);
        accept    = wr_first && !buf_vld_q;
        o_stall   = wr_first && buf_vld_q;
        baud_done = (baud_q == BaudLast);

        unique case (state_q)
            UTX_IDLE: begin
                baud_d = '0;
                load   = buf_vld_q;
            end
            UTX_START: begin
                if (baud_done) begin
                    state_d = UTX_DATA;
                    bit_d   = 3'd0;
                end
            end
            UTX_DATA: begin
                if (baud_done) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = UTX_STOP;
                    end
                end
            end
            UTX_STOP: begin
                if (baud_done) begin
                    if (!byte_hi_q) begin
                        byte_hi_d = 1'b1;
                        state_d   = UTX_START;
                    end else begin
                        state_d = UTX_IDLE;
                        // Chain straight into the next buffered word with no idle gap.
                        load    = buf_vld_q;
                    end
                end
            end
            default: state_d = UTX_IDLE;
        endcase

        if (baud_done) begin
            baud_d = '0;
        end

        if (load) begin
            shift_d   = buf_q;
            buf_vld_d = 1'b0;
            byte_hi_d = 1'b0;
            state_d   = UTX_START;
            baud_d    = '0;
        end

        // Slices 1..3 follow an accepted slice 0 regardless of i_vld.
        if (accept) begin
            buf_d[3:0] = i_data;
            cap_d      = 1'b1;
        end else if (cap_q) begin
            unique case (i_ctr)
                2'd1: buf_d[7:4]  = i_data;
                2'd2: buf_d[11:8] = i_data;
                2'd3: begin
                    buf_d[15:12] = i_data;
                    cap_d        = 1'b0;
                    buf_vld_d    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cur_byte = byte_hi_q ? shift_q[15:8] : shift_q[7:0];
        o_tx     = 1'b1;
        unique case (state_q)
            UTX_IDLE:  o_tx = 1'b1;
            UTX_START: o_tx = 1'b0;
            UTX_DATA:  o_tx = cur_byte[bit_q];
            UTX_STOP:  o_tx = 1'b1;
            default:   o_tx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            cap_q     <= 1'b0;
            shift_q   <= '0;
            state_q   <= UTX_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_hi_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            cap_q     <= cap_d;
            shift_q   <= shift_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_hi_q <= byte_hi_d;
        end
    end

    assign o_debug = '{state: state_q, bit_q: bit_q, byte_hi: byte_hi_q, buf_vld: buf_vld_q};

endmodule

// File: tb/tb_idli_utx.sv
// Bench for idli_utx: a line-level model (queue of expected TX samples) checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_idli_utx;
    import idli_pkg::*;

    localparam int unsigned Cpb = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    ctr_t       ctr;
    logic       vld;
    slice_t     data;
    logic       stall;
    logic       tx;
    utx_debug_t dbg;

    always #5 clk = ~clk;

    idli_utx #(.CYCLES_PER_BIT(Cpb)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ctr   (ctr),
        .i_vld   (vld),
        .i_data  (data),
        .o_stall (stall),
        .o_tx    (tx),
        .o_debug (dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_idle_cyc = 0;

    // Model: expected TX level for each upcoming cycle, plus the buffered word.
    bit          line_q[$];
    logic [15:0] m_word = '0;
    logic        m_bv = 1'b0, m_bv_n, m_cap = 1'b0, m_free;
    logic        model_on = 1'b0;
    logic        exp_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void push_word(input logic [15:0] w);
        for (int b = 0; b < 2; b++) begin
            logic [9:0] fr;
            fr = {1'b1, w[8*b +: 8], 1'b0};
            for (int i = 0; i < 10; i++) begin
                repeat (Cpb) line_q.push_back(fr[i]);
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare against the model, then advance the model with the inputs for the coming edge.
    initial forever begin
        @(negedge clk);
        if (dbg.state == UTX_IDLE) last_idle_cyc = cyc;
        if (model_on) begin
            exp_tx = (line_q.size() > 0) ? line_q[0] : 1'b1;
            check("tx", 32'(tx), 32'(exp_tx));
            check("stall", 32'(stall), 32'(vld && ctr == 2'd0 && m_bv));
            check("buf_vld", 32'(dbg.buf_vld), 32'(m_bv));
            check("idle", 32'(dbg.state == UTX_IDLE), 32'(line_q.size() == 0));
        end
        if (!rst_n) begin
            line_q.delete();
            m_bv     = 1'b0;
            m_cap    = 1'b0;
            m_word   = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            m_bv_n = m_bv;
            m_free = m_bv && (line_q.size() <= 1);
            if (line_q.size() > 0) void'(line_q.pop_front());
            if (m_free) begin
                push_word(m_word);
                m_bv_n = 1'b0;
            end
            if (vld && ctr == 2'd0) begin
                if (!m_bv) begin
                    m_word[3:0] = data;
                    m_cap       = 1'b1;
                end
            end else if (m_cap && ctr != 2'd0) begin
                m_word[4*ctr +: 4] = data;
                if (ctr == 2'd3) begin
                    m_cap  = 1'b0;
                    m_bv_n = 1'b1;
                end
            end
            m_bv = m_bv_n;
        end
    end

    // Call just after a rising edge; replays slice 0 while stalled, like ex does.
    task automatic write_word(input logic [15:0] w, input bit keep_vld,
                              output int stalls, output int acc_cyc);
        bit done = 1'b0;
        stalls  = 0;
        acc_cyc = -1;
        for (int a = 0; a < 64 && !done; a++) begin
            for (int s = 0; s < 4; s++) begin
                ctr  = ctr_t'(s);
                vld  = (s == 0) ? 1'b1 : (done && keep_vld);
                data = (s == 0 || done) ? w[4*s +: 4] : 4'h0;
                @(negedge clk);
                if (s == 0) begin
                    if (stall) stalls++;
                    else begin
                        done    = 1'b1;
                        acc_cyc = cyc;
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        ctr  = 2'd0;
        vld  = 1'b0;
        data = 4'h0;
        check("write_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            ok = (dbg.state == UTX_IDLE) && !dbg.buf_vld && tx;
        end
        check("wait_idle", 32'(ok), 32'd1);
    endtask

    // Finds the next start bit and samples each of the 20 bit periods once.
    task automatic capture_frame(output logic [19:0] bits);
        bit found = 1'b0;
        bits = '0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            found = !tx;
        end
        check("frame_start", 32'(found), 32'd1);
        @(negedge clk);
        bits[0] = tx;
        for (int i = 1; i < 20; i++) begin
            repeat (Cpb) @(negedge clk);
            bits[i] = tx;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [19:0] frame, exp_frame;
    int          s1, s2, s3, a1, a2, a3, bad;
    bit          found;

    initial begin
        rst_n = 1'b0;
        ctr   = 2'd0;
        vld   = 1'b0;
        data  = 4'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state and a quiet line.
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_state", 32'(dbg.state), 32'(UTX_IDLE));
        check("rst_bit", 32'(dbg.bit_q), 32'd0);
        check("rst_byte_hi", 32'(dbg.byte_hi), 32'd0);
        check("rst_buf_vld", 32'(dbg.buf_vld), 32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!tx || stall) bad++;
        end
        check("quiet_100", 32'(bad), 32'd0);

        // 0xA5C3: TX falls two cycles after the ctr==3 capture; 80-cycle word.
        @(posedge clk);
        #1;
        write_word(16'hA5C3, 1'b1, s1, a1);
        @(negedge clk);
        check("tx_pre_fall", 32'(tx), 32'd1);
        @(negedge clk);
        check("tx_fall", 32'(tx), 32'd0);
        capture_frame(frame);
        exp_frame = 20'b1101_0010_1011_1000_0110;
        check("frame_a5c3", 32'(frame), 32'(exp_frame));
        repeat (2) @(negedge clk);
        check("a5c3_done_tx", 32'(tx), 32'd1);
        check("a5c3_done_idle", 32'(dbg.state), 32'(UTX_IDLE));

        // Three writes back to back: replay of the second, long stall of the third, no gaps.
        wait_idle();
        @(posedge clk);
        #1;
        write_word(16'h1234, 1'b1, s1, a1);
        write_word(16'hFFFF, 1'b1, s2, a2);
        write_word(16'hBEEF, 1'b1, s3, a3);
        check("w1_stalls", 32'(s1), 32'd0);
        check("w2_stalls", 32'(s2), 32'd1);
        check("w2_accept_at", 32'(a2 - a1), 32'd8);
        check("w3_stalls", 32'(s3), 32'd19);
        check("w3_accept_at", 32'(a3 - a1), 32'd88);
        for (int i = 0; i < 400 && cyc < a1 + 170; i++) @(negedge clk);
        check("no_idle_gap", 32'(last_idle_cyc - a1), 32'd4);

        // i_vld dropped after slice 0: whole word still captured.
        wait_idle();
        @(posedge clk);
        #1;
        write_word(16'h5A69, 1'b0, s1, a1);
        capture_frame(frame);
        check("partial_vld_word", 32'({frame[18:11], frame[8:1]}), 32'h5A69);
        check("partial_vld_stops", 32'({frame[19], frame[10], frame[9], frame[0]}), 32'b1010);

        // Reset during the high byte with another word buffered: all of it is dropped.
        wait_idle();
        @(posedge clk);
        #1;
        write_word(16'h00C3, 1'b1, s1, a1);
        write_word(16'h7E7E, 1'b1, s2, a2);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = (dbg.state == UTX_DATA) && dbg.byte_hi && (dbg.bit_q == 3'd3);
        end
        check("reach_hi_data", 32'(found), 32'd1);
        check("hi_data_tx", 32'(tx), 32'd0);
        check("hi_data_buffered", 32'(dbg.buf_vld), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_state", 32'(dbg.state), 32'(UTX_IDLE));
        check("mid_rst_buf_vld", 32'(dbg.buf_vld), 32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!tx || dbg.state != UTX_IDLE) bad++;
        end
        check("no_resume", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
